// File: rtl/gpio_pattern_pkg.sv
// gpio_pattern_pkg: register map, field positions and FSM encoding for the pad pattern sequencer.
// Latency: n/a (constants, types and a pure combinational helper only).
// Backpressure: n/a.
package gpio_pattern_pkg;

  // Register select, taken from byte address bits [4:2]
  localparam logic [2:0] REG_CTRL    = 3'd0;  // 0x00
  localparam logic [2:0] REG_DIV     = 3'd1;  // 0x04
  localparam logic [2:0] REG_STATUS  = 3'd2;  // 0x08
  localparam logic [2:0] REG_CAPTURE = 3'd3;  // 0x0C
  localparam logic [2:0] REG_PAT_LO  = 3'd4;  // 0x10
  localparam logic [2:0] REG_PAT_HI  = 3'd5;  // 0x14

  // CTRL bit positions
  localparam int CTRL_START    = 0;
  localparam int CTRL_STOP     = 1;
  localparam int CTRL_LOOP     = 2;
  localparam int CTRL_LAST_LSB = 4;

  // STATUS bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_IDX_LSB = 4;

  // Pattern nibble layout {med, strong, oe, out}
  localparam int PAT_OUT    = 0;
  localparam int PAT_OE     = 1;
  localparam int PAT_STRONG = 2;
  localparam int PAT_MED    = 3;
  localparam int NIB_W      = 4;

  // The table storage and index are always sized for the largest legal DEPTH
  localparam int MAX_DEPTH = 16;
  localparam int IDX_W     = 4;
  localparam int PAT_W     = MAX_DEPTH * NIB_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  // Pick the control nibble for one table entry
  function automatic logic [NIB_W-1:0] pat_entry(input logic [PAT_W-1:0] tbl,
                                                 input logic [IDX_W-1:0] idx);
    pat_entry = tbl[{idx, 2'b00} +: NIB_W];
  endfunction

endpackage

// File: rtl/gpio_pattern_sync.sv
// gpio_pattern_sync: two-flop synchroniser bringing the asynchronous pad readback into the clock domain.
// Latency: 2 cycles from input to output.
// Backpressure: none; samples every cycle.
module gpio_pattern_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; the first may go metastable, the second settles it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/gpio_pattern_gen.sv
// gpio_pattern_gen: Wishbone-programmed sequencer stepping fastio pad controls through a table; optional irq under GPIO_PATTERN_IRQ_EN.
// Latency: ack and read data one cycle after accept; each entry held DIV+1 cycles; pad readback lags 2 cycles.
// Backpressure: none; every accepted access completes on the next cycle with no wait states.
module gpio_pattern_gen
  import gpio_pattern_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DIV_W = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        pad_in,
  output logic        dut_out,
  output logic        dut_oe,
  output logic        dut_strong,
  output logic        dut_med,
  output logic        irq
);

  // Index wrap mask; DEPTH is a power of two no larger than MAX_DEPTH
  localparam logic [IDX_W-1:0] IDX_MASK = IDX_W'(DEPTH - 1);

  // Bus side
  logic             ack_q;
  logic [31:0]      rdat_q;
  logic [31:0]      rdat_d;
  logic             accept;
  logic             wr_en;
  logic [2:0]       reg_sel;
  logic             start_req;
  logic             stop_req;
  logic             done_clr;

  // Configuration registers
  logic             loop_q;
  logic [IDX_W-1:0] last_q;
  logic [DIV_W-1:0] div_q;
  logic [PAT_W-1:0] pat_q;

  // Sequencer state
  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     idx_inc;
  logic [DIV_W-1:0]     cnt_q, cnt_d;
  logic [NIB_W-1:0]     out_q, out_d;
  logic [MAX_DEPTH-1:0] cap_q, cap_d;
  logic                 done_q, done_d;
  logic                 busy;
  logic                 pad_sync;

  // Byte lanes and address bits outside [4:2] carry no meaning here
  logic unused_bus_bits;
  assign unused_bus_bits = ^{wbs_sel_i, wbs_adr_i[31:5], wbs_adr_i[1:0]};

  assign accept  = wbs_stb_i & wbs_cyc_i & ~ack_q;
  assign wr_en   = accept & wbs_we_i;
  assign reg_sel = wbs_adr_i[4:2];

  // A combined start+stop write is treated as a plain stop
  assign start_req = wr_en && (reg_sel == REG_CTRL) &&
                     wbs_dat_i[CTRL_START] && !wbs_dat_i[CTRL_STOP];
  assign stop_req  = wr_en && (reg_sel == REG_CTRL) && wbs_dat_i[CTRL_STOP];
  assign done_clr  = wr_en && (reg_sel == REG_STATUS) && wbs_dat_i[STAT_DONE];

  assign busy    = (state_q != IDLE);
  assign idx_inc = (idx_q + 1'b1) & IDX_MASK;

  gpio_pattern_sync u_sync (
    .clk_i (wb_clk_i),
    .rst_i (wb_rst_i),
    .d_i   (pad_in),
    .q_o   (pad_sync)
  );

  // Configuration writes; the sequencer only picks these up at its next step load
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      loop_q <= 1'b0;
      last_q <= IDX_MASK;
      div_q  <= '0;
      pat_q  <= '0;
    end else if (wr_en) begin
      case (reg_sel)
        REG_CTRL: begin
          loop_q <= wbs_dat_i[CTRL_LOOP];
          last_q <= wbs_dat_i[CTRL_LAST_LSB +: IDX_W] & IDX_MASK;
        end
        REG_DIV:    div_q         <= wbs_dat_i[DIV_W-1:0];
        REG_PAT_LO: pat_q[31:0]   <= wbs_dat_i;
        REG_PAT_HI: pat_q[63:32]  <= wbs_dat_i;
        default: ;
      endcase
    end
  end

  // Read mux; unmapped selects return zero
  always_comb begin
    rdat_d = '0;
    case (reg_sel)
      REG_CTRL: begin
        rdat_d[CTRL_LOOP]               = loop_q;
        rdat_d[CTRL_LAST_LSB +: IDX_W]  = last_q;
      end
      REG_DIV:     rdat_d[DIV_W-1:0]     = div_q;
      REG_STATUS: begin
        rdat_d[STAT_BUSY]               = busy;
        rdat_d[STAT_DONE]               = done_q;
        rdat_d[STAT_IDX_LSB +: IDX_W]   = idx_q;
      end
      REG_CAPTURE: rdat_d[MAX_DEPTH-1:0] = cap_q;
      REG_PAT_LO:  rdat_d                = pat_q[31:0];
      REG_PAT_HI:  rdat_d                = pat_q[63:32];
      default: ;
    endcase
  end

  // Single-cycle registered ack with read data launched alongside it
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q  <= 1'b0;
      rdat_q <= '0;
    end else begin
      ack_q  <= accept;
      rdat_q <= (accept && !wbs_we_i) ? rdat_d : '0;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdat_q;

  // Sequencer registers: state, step index and counter, pad drive, capture and done
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      cap_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      cap_q   <= cap_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: load an entry, count it down, sample the pad, advance or finish
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    cap_d   = cap_q;
    done_d  = done_q;

    if (done_clr) begin
      done_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        out_d = '0;
        if (start_req) begin
          idx_d   = '0;
          cnt_d   = div_q;
          out_d   = pat_entry(pat_q, '0);
          cap_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        if (stop_req) begin
          out_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          cap_d[idx_q] = pad_sync;
          if (idx_q != last_q) begin
            idx_d = idx_inc;
            cnt_d = div_q;
            out_d = pat_entry(pat_q, idx_inc);
          end else if (loop_q) begin
            idx_d = '0;
            cnt_d = div_q;
            out_d = pat_entry(pat_q, '0);
          end else begin
            out_d   = '0;
            state_d = FINISH;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      FINISH: begin
        // Setting done here overrides a clear arriving in the same cycle
        out_d   = '0;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        out_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign dut_out    = out_q[PAT_OUT];
  assign dut_oe     = out_q[PAT_OE];
  assign dut_strong = out_q[PAT_STRONG];
  assign dut_med    = out_q[PAT_MED];

`ifdef GPIO_PATTERN_IRQ_EN
  assign irq = (state_q == FINISH);
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_pattern_gen.sv
// tb_gpio_pattern_gen: directed and randomised sequences against a step-table reference model.
// Latency: checks ack one cycle after accept and entry hold of DIV+1 cycles.
// Backpressure: n/a; the bench issues one Wishbone access at a time.
module tb_gpio_pattern_gen;

  localparam logic [31:0] A_CTRL = 32'h00;
  localparam logic [31:0] A_DIV  = 32'h04;
  localparam logic [31:0] A_STAT = 32'h08;
  localparam logic [31:0] A_CAP  = 32'h0C;
  localparam logic [31:0] A_PLO  = 32'h10;
  localparam logic [31:0] A_PHI  = 32'h14;

`ifdef GPIO_PATTERN_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic        cyc_o = 1'b0;
  logic        we = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] wdat = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        pad_in = 1'b0;
  logic        dut_out, dut_oe, dut_strong, dut_med, irq;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  gpio_pattern_gen dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbs_stb_i  (stb),
    .wbs_cyc_i  (cyc_o),
    .wbs_we_i   (we),
    .wbs_sel_i  (4'hF),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (wdat),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_dat_o  (wbs_dat_o),
    .pad_in     (pad_in),
    .dut_out    (dut_out),
    .dut_oe     (dut_oe),
    .dut_strong (dut_strong),
    .dut_med    (dut_med),
    .irq        (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {dut_med, dut_strong, dut_oe, dut_out};
  endfunction

  function automatic logic [3:0] nib(input logic [63:0] p, input int k);
    logic [63:0] t;
    t = (p >> (4 * k)) & 64'hF;
    return t[3:0];
  endfunction

  // One access; returns #1 after the accept edge, when ack must be high
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd);
    int n;
    n = 0;
    @(negedge clk);
    while (wbs_ack_o !== 1'b0 && n < 4) begin
      @(negedge clk);
      n++;
    end
    stb = 1'b1; cyc_o = 1'b1; we = w; adr = a; wdat = d;
    @(posedge clk);
    #1;
    stb = 1'b0; cyc_o = 1'b0; we = 1'b0;
    rd = wbs_dat_o;
    check("ack_high", {31'h0, wbs_ack_o}, 32'h1);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    wb_xfer(1'b1, a, d, rd);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] mask,
                        input logic [31:0] exp);
    logic [31:0] rd;
    wb_xfer(1'b0, a, 32'h0, rd);
    check(tag, rd & mask, exp);
    @(posedge clk);
    #1;
    check({tag, "_ack_once"}, {31'h0, wbs_ack_o}, 32'h0);
  endtask

  // Run a non-looping sequence and compare against the step-table model.
  // pad_mode: 0 = pad high during steps 1 and 3, 1 = random per cycle, 2 = held low.
  task automatic run_seq(input string tag, input logic [63:0] pat, input int div,
                         input int last, input int pad_mode, input bit restart);
    int          total, c, s, j;
    logic        p_before;
    logic        pv [0:127];
    logic [31:0] exp_cap;
    logic [3:0]  exp_o;
    total    = (last + 1) * (div + 1);
    p_before = (pad_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    for (int i = 0; i < 128; i++) begin
      case (pad_mode)
        0:       pv[i] = ((i / (div + 1)) == 1) || ((i / (div + 1)) == 3);
        1:       pv[i] = 1'($urandom_range(0, 1));
        default: pv[i] = 1'b0;
      endcase
    end
    // Step k ends at clock edge (k+1)*(div+1) after start; the captured bit is the
    // pad as it stood two edges earlier. pv[c] is driven in cycle c, seen at edge c+1.
    exp_cap = '0;
    for (int k = 0; k <= last; k++) begin
      j = (k + 1) * (div + 1) - 2;
      exp_cap[k] = (j <= 0) ? p_before : pv[j - 1];
    end

    pad_in = p_before;
    wb_write(A_DIV, 32'(div));
    wb_write(A_PLO, pat[31:0]);
    wb_write(A_PHI, pat[63:32]);
    wb_write(A_CTRL, 32'(last << 4) | 32'h1);

    s = cyc;
    c = 0;
    while (c <= total + 2) begin
      exp_o = (c < total) ? nib(pat, c / (div + 1)) : 4'h0;
      check({tag, "_out"}, {28'h0, outs()}, {28'h0, exp_o});
      check({tag, "_irq"}, {31'h0, irq}, {31'h0, IRQ_ON && (c == total)});
      pad_in = pv[c];
      if (restart && c == 1) begin
        wb_write(A_CTRL, 32'(last << 4) | 32'h1);
      end else begin
        @(posedge clk);
        #1;
      end
      c = cyc - s;
    end

    rd_chk({tag, "_capture"}, A_CAP, 32'hFFFF, exp_cap);
    rd_chk({tag, "_status_done"}, A_STAT, 32'h3, 32'h2);
    wb_write(A_STAT, 32'h2);
    rd_chk({tag, "_status_clr"}, A_STAT, 32'h3, 32'h0);
  endtask

  initial begin
    logic [63:0] p;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {28'h0, outs()}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_ack", {31'h0, wbs_ack_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rd_chk("rst_ctrl", A_CTRL, 32'hFFFF_FFFF, 32'hF0);
    rd_chk("rst_div", A_DIV, 32'hFFFF_FFFF, 32'h0);
    rd_chk("rst_status", A_STAT, 32'hFFFF_FFFF, 32'h0);
    rd_chk("rst_capture", A_CAP, 32'hFFFF_FFFF, 32'h0);
    rd_chk("rst_pat_lo", A_PLO, 32'hFFFF_FFFF, 32'h0);
    rd_chk("rst_pat_hi", A_PHI, 32'hFFFF_FFFF, 32'h0);
    wb_write(32'h18, 32'hFFFF_FFFF);
    rd_chk("unmapped_18", 32'h18, 32'hFFFF_FFFF, 32'h0);
    rd_chk("unmapped_1c", 32'h1C, 32'hFFFF_FFFF, 32'h0);
    rd_chk("ctrl_after_unmapped", A_CTRL, 32'hFFFF_FFFF, 32'hF0);

    // Four-entry pattern, 3 cycles per step, pad high in steps 1 and 3
    run_seq("seq4321", 64'h4321, 2, 3, 0, 1'b0);
    rd_chk("capture_0A", A_CAP, 32'hFFFF, 32'h000A);
    rd_chk("pat_lo_readback", A_PLO, 32'hFFFF_FFFF, 32'h0000_4321);

    // Looping two-entry sequence at one cycle per step, then stop
    wb_write(A_DIV, 32'h0);
    wb_write(A_PLO, 32'h65);
    wb_write(A_CTRL, 32'h15);
    for (int c = 0; c < 8; c++) begin
      check("loop_alt", {28'h0, outs()}, (c % 2 == 0) ? 32'h5 : 32'h6);
      @(posedge clk);
      #1;
    end
    wb_write(A_CTRL, 32'h16);
    check("stop_outs", {28'h0, outs()}, 32'h0);
    @(posedge clk);
    #1;
    check("stop_outs_hold", {28'h0, outs()}, 32'h0);
    rd_chk("stop_status", A_STAT, 32'h3, 32'h0);

    // Start and stop in the same write stays idle
    wb_write(A_CTRL, 32'h3);
    check("startstop_outs", {28'h0, outs()}, 32'h0);
    @(posedge clk);
    #1;
    check("startstop_outs2", {28'h0, outs()}, 32'h0);
    rd_chk("startstop_busy", A_STAT, 32'h1, 32'h0);

    // Start while busy must not disturb the running sequence
    p = {$urandom, $urandom};
    run_seq("busy_start", p, 3, 3, 2, 1'b1);

    // One-entry sequence
    p = {$urandom, $urandom};
    run_seq("last0", p, int'($urandom_range(0, 3)), 0, 1, 1'b0);

    // Randomised sequences
    for (int r = 0; r < 6; r++) begin
      p = {$urandom, $urandom};
      run_seq("rand", p, int'($urandom_range(0, 4)), int'($urandom_range(0, 15)), 1, 1'b0);
    end

    // Asynchronous reset in the middle of step 2
    wb_write(A_DIV, 32'h3);
    wb_write(A_PLO, 32'h0000_7C5A);
    wb_write(A_CTRL, 32'h31);
    repeat (9) @(posedge clk);
    #1;
    check("midrun_step2", {28'h0, outs()}, 32'hC);
    rst = 1'b1;
    #1;
    check("midrun_rst_outs", {28'h0, outs()}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rd_chk("midrun_status", A_STAT, 32'hFFFF_FFFF, 32'h0);
    rd_chk("midrun_ctrl", A_CTRL, 32'hFFFF_FFFF, 32'hF0);
    rd_chk("midrun_div", A_DIV, 32'hFFFF_FFFF, 32'h0);
    rd_chk("midrun_capture", A_CAP, 32'hFFFF_FFFF, 32'h0);
    rd_chk("midrun_pat_lo", A_PLO, 32'hFFFF_FFFF, 32'h0);
    check("midrun_outs_after", {28'h0, outs()}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_pattern_gen.md
Name: gpio_pattern_gen

Overview:
- Wishbone-programmable stimulus sequencer that drives the four control lines of the fastio DUT pad: output, output-enable, strong, medium.
- Steps through a small pattern table at a programmable rate.
- Captures the synchronised pad readback once per step.
- Sits directly upstream of the test-chip pad wrapper and replaces external stimulus on the fastio input pins with on-chip, register-driven sequences.

Parameters:
- DEPTH, 16, number of pattern entries; must be a power of two, maximum 16.
- DIV_W, 16, width of the step-period divider.

Ports:
- wb_clk_i  in  1  single clock for all logic.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects; ignored, all writes are full-word.
- wbs_adr_i  in  32  byte address; bits [4:2] decode the register.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- pad_in  in  1  asynchronous readback from the DUT pad.
- dut_out  out  1  pad output value.
- dut_oe  out  1  pad output enable, active-high.
- dut_strong  out  1  strong drive enable.
- dut_med  out  1  medium drive enable.
- irq  out  1  one-cycle done pulse.

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE, index 0.
  - DIV 0, pattern table 0, capture 0.
  - done 0, loop 0, LAST = DEPTH-1.
- Wishbone access:
  - Accept when stb&cyc&!ack.
  - ack is registered: high exactly one cycle, on the cycle after accept; no wait states.
  - Read data is registered alongside ack.
  - Unmapped addresses read 0; writes to them are ignored.
- Register map (byte offsets):
  - 0x00 CTRL: [0] start (write-1 pulse), [1] stop (write-1 pulse), [2] loop (R/W), [7:4] LAST, last entry index (R/W).
  - 0x04 DIV: [DIV_W-1:0]. Each step lasts DIV+1 cycles.
  - 0x08 STATUS: [0] busy (RO), [1] done (sticky, write-1-to-clear), [7:4] current index (RO).
  - 0x0C CAPTURE (RO): bit i holds the synchronised pad_in sampled at the end of step i.
  - 0x10 PAT_LO: entries 0-7, nibble k = {med, strong, oe, out} for entry k.
  - 0x14 PAT_HI: entries 8-15, same nibble layout.
- pad_in passes through a 2-flop synchroniser; sampled data lags the pad by 2 cycles.
- FSM states:
  - IDLE:
    - All DUT outputs 0.
    - On the accept edge of a start write: idx<=0, cnt<=DIV, outputs<=PAT[0], go to RUN.
  - RUN:
    - busy=1; cnt decrements each cycle.
    - At cnt==0: CAPTURE[idx]<=pad_sync.
    - If idx!=LAST: idx<=idx+1, cnt<=DIV, outputs<=PAT[idx+1].
    - Else if loop=1: idx<=0, cnt<=DIV, outputs<=PAT[0].
    - Else go to FINISH.
  - FINISH:
    - One cycle: outputs<=0, done<=1, irq pulse; then IDLE.
- Timing: entry k is visible on the DUT outputs for exactly DIV+1 cycles.
- Start/stop rules:
  - Start while busy is ignored.
  - Stop in RUN: next edge goes to IDLE, outputs 0, done unchanged, CAPTURE retains partial results.
  - Start and stop in the same write: stop wins; start is not acted on.
- CAPTURE is cleared to 0 when a start is accepted.
- Pattern, DIV or LAST writes during RUN take effect at the next step load.
- LAST=0 is a one-entry sequence.
- A done-clear write in the same cycle FINISH sets done: set wins.
- An asynchronous reset mid-run forces the full reset state immediately.

Optional Feature:
- Macro GPIO_PATTERN_IRQ_EN.
- Defined: irq pulses high for one cycle in FINISH.
- Undefined: irq is tied 0. done status is unaffected.

Decomposition:
- Package gpio_pattern_pkg holds:
  - Register offsets.
  - CTRL and STATUS bit positions.
  - FSM state enum {IDLE, RUN, FINISH}.
  - Pattern nibble field positions.
- Sub-module gpio_pattern_sync: 2-flop synchroniser with async active-high reset to 0.

Test Plan:
- Reset, then read all registers -> CTRL=0xF0, all others 0. Every read acks exactly one cycle after accept.
- PAT_LO=0x0000_4321, DIV=2, LAST=3, start -> outputs 1,2,3,4 each held 3 cycles, then 0. done=1; irq pulses once (with GPIO_PATTERN_IRQ_EN).
- Drive pad_in=1 during steps 1 and 3 only, same pattern as above -> CAPTURE=0x000A.
- loop=1, LAST=1, DIV=0 -> outputs alternate PAT[0]/PAT[1] every cycle. Write stop -> outputs 0 next cycle, busy=0, done=0.
- Write start|stop together (0x3) -> stays IDLE. Start while busy -> idx sequence unaffected.
- Assert wb_rst_i mid-RUN at idx=2 -> outputs 0 immediately, STATUS reads 0 after release.
